freq_bcd_formatter: RTL and testbench

- Sits directly upstream of the LCD display controller.
- Takes the raw binary frequency count from the gate counter (Hz, one count per 1 s gate).
- Converts it to BCD with a serial shift-add-3 (double-dabble) engine and selects the kHz decimal-point position.
- Presents 4 significant digits as LCD character codes on Latch3_LCD..Latch0_LCD with a matching DotLed, then pulses Store for one cycle.

---
 rtl/freq_bcd_formatter.sv | 114 +++++++++++
 tb/tb_freq_bcd_formatter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/freq_bcd_formatter.sv
// freq_bcd_formatter: serial double-dabble of a Hz count into 4 kHz-scaled LCD digits plus decimal point.
module freq_bcd_formatter #(
  parameter int CNT_W = 24
) (
  input  logic             CLK_50,
  input  logic             nRST,
  input  logic [CNT_W-1:0] count,
  input  logic             count_valid,
  output logic             busy,
  output logic             Store,
  output logic [8:0]       Latch3_LCD,
  output logic [8:0]       Latch2_LCD,
  output logic [8:0]       Latch1_LCD,
  output logic [8:0]       Latch0_LCD,
  output logic [2:0]       DotLed,
  output logic             ovf
);
  typedef enum logic [2:0] {IDLE, SHIFT, SELECT, OUT, DONE} state_t;
  localparam logic [4:0] LAST = 5'(CNT_W - 1);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] bin_q, bin_d;
  logic [31:0]      bcd_q, bcd_d, adj;
  logic [4:0]       iter_q, iter_d;
  logic [2:0]       h_q, h_d, hi, sh;
  logic             busy_q, busy_d, store_q, store_d, ovf_q, ovf_d;
  logic [2:0]       dot_q, dot_d;
  logic [3:0][8:0]  lat_q, lat_d;
  logic [15:0]      win;
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    h_d     = h_q;
    busy_d  = busy_q;
    store_d = store_q;
    ovf_d   = ovf_q;
    dot_d   = dot_q;
    lat_d   = lat_q;
    adj     = bcd_q;
    for (int i = 0; i < 8; i++)
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    hi = 3'd0;
    for (int i = 1; i < 8; i++)
      if (bcd_q[4*i +: 4] != 4'd0) hi = 3'(i);
    sh  = (h_q > 3'd3) ? h_q - 3'd3 : 3'd0;
    win = 16'(bcd_q >> {sh, 2'b00});
    unique case (state_q)
      IDLE: if (count_valid) begin
        bin_d   = count;
        bcd_d   = '0;
        iter_d  = '0;
        busy_d  = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        {bcd_d, bin_d} = {adj, bin_q} << 1;
        iter_d  = iter_q + 5'd1;
        state_d = (iter_q == LAST) ? SELECT : SHIFT;
      end
      SELECT: begin
        h_d     = hi;
        state_d = OUT;
      end
      OUT: begin
        store_d = 1'b1;
        ovf_d   = (h_q == 3'd7);
        dot_d   = (h_q <= 3'd3) ? 3'b100 : (h_q == 3'd4) ? 3'b010 : (h_q == 3'd5) ? 3'b001 : 3'b000;
        for (int j = 0; j < 4; j++)
          lat_d[j] = (h_q == 3'd7) ? 9'h12D : {1'b1, 4'h3, win[4*j +: 4]};
        state_d = DONE;
      end
      DONE: begin
        store_d = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK_50 or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      h_q     <= '0;
      busy_q  <= 1'b0;
      store_q <= 1'b0;
      ovf_q   <= 1'b0;
      dot_q   <= 3'b000;
      lat_q   <= {4{9'h120}};
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      iter_q  <= iter_d;
      h_q     <= h_d;
      busy_q  <= busy_d;
      store_q <= store_d;
      ovf_q   <= ovf_d;
      dot_q   <= dot_d;
      lat_q   <= lat_d;
    end
  end
  assign busy       = busy_q;
  assign Store      = store_q;
  assign ovf        = ovf_q;
  assign DotLed     = dot_q;
  assign Latch3_LCD = lat_q[3];
  assign Latch2_LCD = lat_q[2];
  assign Latch1_LCD = lat_q[1];
  assign Latch0_LCD = lat_q[0];
endmodule

// File: tb/tb_freq_bcd_formatter.sv
// tb_freq_bcd_formatter: scoreboard bench comparing the formatter against a decimal-arithmetic model.
module tb_freq_bcd_formatter;
  localparam int CNT_W = 24;
  localparam logic [39:0] RST_OUT = {{4{9'h120}}, 3'b000, 1'b0};
  typedef struct {
    int          t;
    logic [39:0] o;
  } exp_t;
  logic             CLK_50 = 1'b0;
  logic             nRST = 1'b0;
  logic [CNT_W-1:0] count = '0;
  logic             count_valid = 1'b0;
  logic             busy, Store, ovf;
  logic [8:0]       l3, l2, l1, l0;
  logic [2:0]       DotLed;
  int               total = 0, bad = 0, cyc = 0;
  int               busy_k = -1000, free_cyc = 0;
  logic [39:0]      cur = RST_OUT;
  exp_t             q[$];
  freq_bcd_formatter #(.CNT_W(CNT_W)) dut (
    .CLK_50(CLK_50), .nRST(nRST), .count(count), .count_valid(count_valid),
    .busy(busy), .Store(Store), .Latch3_LCD(l3), .Latch2_LCD(l2),
    .Latch1_LCD(l1), .Latch0_LCD(l0), .DotLed(DotLed), .ovf(ovf)
  );
  always #10 CLK_50 = ~CLK_50;
  always @(posedge CLK_50) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s at cycle %0d: got=%0h exp=%0h", n, cyc, a, e);
    end
  endtask
  function automatic logic [39:0] model(input int v);
    int d;
    logic [2:0] dot;
    logic [35:0] l;
    if (v >= 10000000) return {{4{9'h12D}}, 3'b000, 1'b1};
    if (v < 10000) begin d = v; dot = 3'b100; end
    else if (v < 100000) begin d = v / 10; dot = 3'b010; end
    else if (v < 1000000) begin d = v / 100; dot = 3'b001; end
    else begin d = v / 1000; dot = 3'b000; end
    for (int j = 0; j < 4; j++) begin
      l[9*j +: 9] = 9'h130 + 9'(d % 10);
      d = d / 10;
    end
    return {l, dot, 1'b0};
  endfunction
  always @(negedge CLK_50) begin
    exp_t e;
    if (Store) begin
      if (q.size() == 0) chk("unexpected_store", 1, 0);
      else begin
        e = q.pop_front();
        chk("store_time", 64'(cyc), 64'(e.t));
        cur = e.o;
      end
    end
    chk("outputs", {l3, l2, l1, l0, DotLed, ovf}, cur);
    chk("busy", busy, (cyc >= busy_k && cyc < busy_k + CNT_W + 3));
  end
  task automatic strobe(input int v);
    exp_t e;
    @(negedge CLK_50);
    count = v[CNT_W-1:0];
    count_valid = 1'b1;
    if (cyc + 1 >= free_cyc) begin
      e.t = cyc + 1 + CNT_W + 2;
      e.o = model(v);
      q.push_back(e);
      busy_k = cyc + 1;
      free_cyc = cyc + 1 + CNT_W + 4;
    end
    @(negedge CLK_50);
    count_valid = 1'b0;
    count = CNT_W'($urandom);
  endtask
  task automatic idle();
    while (cyc + 1 < free_cyc) @(negedge CLK_50);
  endtask
  task automatic pulse_reset();
    @(negedge CLK_50);
    #2 nRST = 1'b0;
    q.delete();
    cur = RST_OUT;
    busy_k = -1000;
    free_cyc = 0;
    @(negedge CLK_50);
    #2 nRST = 1'b1;
  endtask
  initial begin
    int dir[9] = '{1234, 56789, 456789, 9999999, 0, 999, 10000000, 16777215, 5000};
    int v, n;
    repeat (3) @(negedge CLK_50);
    #2 nRST = 1'b1;
    foreach (dir[i]) begin
      strobe(dir[i]);
      idle();
    end
    strobe(1234);
    repeat (3) @(negedge CLK_50);
    strobe(5678);
    idle();
    strobe(5678);
    repeat (CNT_W + 1) @(negedge CLK_50);
    strobe(4321);
    idle();
    strobe(1234);
    repeat (8) @(negedge CLK_50);
    pulse_reset();
    strobe(87654);
    idle();
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: v = $urandom_range(0, 9999);
        1: v = $urandom_range(10000, 99999);
        2: v = $urandom_range(100000, 999999);
        3: v = $urandom_range(1000000, 9999999);
        default: v = $urandom_range(10000000, 16777215);
      endcase
      strobe(v);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, CNT_W)) @(negedge CLK_50);
        strobe($urandom_range(0, 16777215));
      end
      idle();
      repeat ($urandom_range(0, 3)) @(negedge CLK_50);
    end
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge CLK_50);
      n++;
    end
    repeat (3) @(negedge CLK_50);
    chk("drain", 64'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
